// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps one memory read outstanding, holds the fetched
// word for decode until it is accepted, and handles branch redirect and HLT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] COMMAND,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        PC_load,
    input  logic [15:0] pc_target,
    output logic [15:0] pc_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic        halted_q, halted_d;
    logic        accept_s;

    function automatic logic is_hlt(input logic [15:0] word);
        return (word[15:14] == 2'b11) && (word[7:4] == 4'b1111);
    endfunction

    assign accept_s = valid_q & cmd_ready;

    // Next-state and next-output logic for the fetch sequencer
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cmd_d    = cmd_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        req_d    = req_q;
        halted_d = halted_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                // An ack only counts while the request is actually raised.
                if (req_q && mem_ack) begin
                    cmd_d    = mem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = HOLD;
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (accept_s) begin
                    valid_d = 1'b0;
                    if (is_hlt(cmd_q)) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        pc_d    = PC_load ? pc_target : (pc_q + 16'd1);
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            HALT: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
                state_d  = HALT;
            end
            default: begin
                state_d  = IDLE;
                pc_d     = RESET_PC;
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything without waiting for clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            cmd_q    <= 16'h0000;
            pc_out_q <= 16'h0000;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cmd_q    <= cmd_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
            halted_q <= halted_d;
        end
    end

    assign mem_addr  = pc_q;
    assign mem_req   = req_q;
    assign COMMAND   = cmd_q;
    assign cmd_valid = valid_q;
    assign pc_out    = pc_out_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a behavioural model and at key points against literal values.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        cmd_ready = 1'b0;
    logic        PC_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;
    logic [15:0] mem_addr, COMMAND, pc_out;
    logic        mem_req, cmd_valid, halted;

    logic [15:0] w_addr, w_cmd, w_pcout;
    logic        w_req, w_valid, w_halted;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [0:255];

    // behavioural model state
    logic        m_idle = 1'b1, m_halted = 1'b0, m_req = 1'b0, m_valid = 1'b0;
    logic [15:0] m_pc = 16'h0000, m_cmd = 16'h0000, m_pcout = 16'h0000;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .COMMAND(COMMAND),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .PC_load(PC_load),
        .pc_target(pc_target), .pc_out(pc_out), .halted(halted)
    );

    // second instance: reset vector at the top of memory, memory always answers at once
    fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .mem_addr(w_addr), .mem_req(w_req),
        .mem_ack(w_req), .mem_rdata(16'h0000), .COMMAND(w_cmd),
        .cmd_valid(w_valid), .cmd_ready(1'b1), .PC_load(1'b0),
        .pc_target(16'h0000), .pc_out(w_pcout), .halted(w_halted)
    );

    always #5 clk = ~clk;

    function automatic logic is_hlt(input logic [15:0] w);
        return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
    endfunction

    // Reference model: the fetch rules applied once per clock edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle <= 1'b1; m_halted <= 1'b0; m_req <= 1'b0; m_valid <= 1'b0;
            m_pc <= 16'h0000; m_cmd <= 16'h0000; m_pcout <= 16'h0000;
        end else if (m_idle) begin
            m_idle <= 1'b0;
            m_req  <= 1'b1;
        end else if (m_halted) begin
            m_req <= 1'b0;
        end else if (m_req && mem_ack) begin
            m_cmd   <= mem[m_pc[7:0]];
            m_pcout <= m_pc;
            m_valid <= 1'b1;
            m_req   <= 1'b0;
        end else if (m_valid && cmd_ready) begin
            m_valid <= 1'b0;
            if (is_hlt(m_cmd)) begin
                m_halted <= 1'b1;
            end else begin
                m_pc  <= PC_load ? pc_target : m_pc + 16'd1;
                m_req <= 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            n_vec++;
            if (mem_addr != m_pc || mem_req != m_req || COMMAND != m_cmd ||
                cmd_valid != m_valid || pc_out != m_pcout || halted != m_halted) begin
                n_err++;
                $display("FAIL model t=%0t got addr=%h req=%b cmd=%h vld=%b pco=%h hlt=%b want addr=%h req=%b cmd=%h vld=%b pco=%h hlt=%b",
                         $time, mem_addr, mem_req, COMMAND, cmd_valid, pc_out, halted,
                         m_pc, m_req, m_cmd, m_valid, m_pcout, m_halted);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    // drive one cycle of inputs, then advance to just after the next edge
    task automatic cyc(input logic ack, input logic rdy, input logic ld, input logic [15:0] tgt);
        mem_ack   = ack;
        mem_rdata = ack ? mem[mem_addr[7:0]] : 16'($urandom);
        cmd_ready = rdy;
        PC_load   = ld;
        pc_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_req", {15'd0, mem_req}, 16'h0000);
        chk("rst_cmd", COMMAND, 16'h0000);
        chk("rst_pcout", pc_out, 16'h0000);
        chk("rst_valid", {15'd0, cmd_valid}, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (is_hlt(w)) w[4] = 1'b0;
            mem[i] = w;
        end
        mem[8'h00] = 16'h8105;
        mem[8'h01] = 16'hC060;
        mem[8'h02] = 16'h1234;
        #1;
        reset_dut();

        // sequential run, and the wrap instance alongside
        chk("seq_idle_req", {15'd0, mem_req}, 16'h0000);
        chk("wrap_reset_addr", w_addr, 16'hFFFF);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("seq_f0_req", {15'd0, mem_req}, 16'h0001);
        chk("seq_f0_addr", mem_addr, 16'h0000);
        chk("seq_f0_valid", {15'd0, cmd_valid}, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("seq_c0_cmd", COMMAND, 16'h8105);
        chk("seq_c0_pcout", pc_out, 16'h0000);
        chk("seq_c0_valid", {15'd0, cmd_valid}, 16'h0001);
        chk("wrap_pcout", w_pcout, 16'hFFFF);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("seq_f1_addr", mem_addr, 16'h0001);
        chk("seq_f1_valid", {15'd0, cmd_valid}, 16'h0000);
        chk("wrap_next_addr", w_addr, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("seq_c1_cmd", COMMAND, 16'hC060);
        chk("seq_c1_pcout", pc_out, 16'h0001);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("seq_f2_addr", mem_addr, 16'h0002);
        chk("seq_f2_valid", {15'd0, cmd_valid}, 16'h0000);

        // slow memory then back-pressure
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            chk("slow_addr", mem_addr, 16'h0002);
            chk("slow_req", {15'd0, mem_req}, 16'h0001);
        end
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("bp_cmd", COMMAND, 16'h1234);
        chk("bp_pcout", pc_out, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            chk("bp_hold_cmd", COMMAND, 16'h1234);
            chk("bp_hold_valid", {15'd0, cmd_valid}, 16'h0001);
            chk("bp_hold_req", {15'd0, mem_req}, 16'h0000);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("bp_accept_valid", {15'd0, cmd_valid}, 16'h0000);
        chk("bp_accept_addr", mem_addr, 16'h0003);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("bp_single_addr", mem_addr, 16'h0003);
        chk("bp_single_valid", {15'd0, cmd_valid}, 16'h0000);

        // branch redirect and ignored PC_load outside accept
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h0010);
        chk("br_to10", mem_addr, 16'h0010);
        cyc(1'b1, 1'b0, 1'b1, 16'h0099);
        chk("br_pcout10", pc_out, 16'h0010);
        cyc(1'b0, 1'b0, 1'b1, 16'h0077);
        cyc(1'b0, 1'b1, 1'b1, 16'h0040);
        chk("br_taken", mem_addr, 16'h0040);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h0010);
        cyc(1'b1, 1'b0, 1'b1, 16'h0055);
        cyc(1'b0, 1'b0, 1'b1, 16'h0055);
        cyc(1'b0, 1'b1, 1'b0, 16'h0055);
        chk("br_not_taken", mem_addr, 16'h0011);

        // random traffic, checked by the model only
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        // async reset in the middle of a fetch
        mem[8'h30] = 16'hC0F0;
        reset_dut();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h0023);
        chk("ar_pre_addr", mem_addr, 16'h0023);
        chk("ar_pre_req", {15'd0, mem_req}, 16'h0001);
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[7:0]];
        cmd_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("ar_req_drop", {15'd0, mem_req}, 16'h0000);
        chk("ar_addr_rst", mem_addr, 16'h0000);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_refetch_req", {15'd0, mem_req}, 16'h0001);
        chk("ar_refetch_addr", mem_addr, 16'h0000);
        chk("ar_ack_dropped", {15'd0, cmd_valid}, 16'h0000);

        // halt
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("ar_cmd", COMMAND, 16'h8105);
        cyc(1'b0, 1'b1, 1'b1, 16'h0030);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("hlt_cmd", COMMAND, 16'hC0F0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0050);
        chk("hlt_halted", {15'd0, halted}, 16'h0001);
        chk("hlt_pc_kept", mem_addr, 16'h0030);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 16'($urandom));
            chk("hlt_stay", {13'd0, halted, mem_req, cmd_valid}, 16'h0004);
        end

        // reset out of halt
        reset_dut();
        chk("post_hlt_halted", {15'd0, halted}, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("post_hlt_req", {15'd0, mem_req}, 16'h0001);
        chk("post_hlt_addr", mem_addr, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: first instruction address after reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 mem_addr  output  16  instruction memory word address (= PC).
REQ-006 mem_req  output  1  read request, held high until accepted.
REQ-007 mem_ack  input  1  memory completes read this cycle; mem_rdata valid.
REQ-008 mem_rdata  input  16  instruction word.
REQ-009 COMMAND  output  16  held instruction presented to decode.
REQ-010 cmd_valid  output  1  COMMAND is valid.
REQ-011 cmd_ready  input  1  decode/execute consumes COMMAND this cycle.
REQ-012 PC_load  input  1  taken-branch redirect, qualified by accept.
REQ-013 pc_target  input  16  redirect address.
REQ-014 pc_out  output  16  address the held COMMAND was fetched from.
REQ-015 halted  output  1  HLT retired; fetch stopped.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, HOLD, HALT.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-018 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal PC, both stable until the mem_ack cycle.
REQ-019 On clk edge with mem_req=1 and mem_ack=1: COMMAND <= mem_rdata, pc_out <= PC, cmd_valid <= 1, mem_req <= 0, state -> HOLD.
REQ-020 mem_ack while mem_req=0 SHALL be ignored; no state or data change.
REQ-021 Minimum fetch latency SHALL be 1 cycle (ack in first FETCH cycle -> cmd_valid next cycle); wait cycles unbounded.
REQ-022 In HOLD, COMMAND, pc_out and cmd_valid=1 SHALL be held unchanged until accept (cmd_valid & cmd_ready).
REQ-023 On accept with PC_load=1: PC <= pc_target; otherwise PC <= PC + 1 mod 2^16 (16'hFFFF wraps to 16'h0000).
REQ-024 On accept, cmd_valid SHALL drop to 0 next cycle and state -> FETCH (one outstanding fetch; one bubble per instruction).
REQ-025 PC_load and pc_target SHALL be ignored outside accept cycles.
REQ-026 HLT = COMMAND[15:14]==2'b11 and COMMAND[7:4]==4'b1111.
REQ-027 On accept of HLT: state -> HALT, PC unchanged, PC_load ignored.
REQ-028 In HALT: mem_req=0, cmd_valid=0, halted=1; only reset exits.
REQ-029 halted SHALL be 0 in all states except HALT.

Reset
REQ-030 rst=1 SHALL force, without waiting for clk: state IDLE, PC=RESET_PC, mem_addr=RESET_PC, mem_req=0, COMMAND=16'h0000, pc_out=16'h0000, cmd_valid=0, halted=0.
REQ-031 Reset during FETCH SHALL drop mem_req immediately; a mem_ack arriving with rst or after it (while mem_req=0) SHALL be discarded.
REQ-032 Reset during HOLD or HALT SHALL discard the held instruction; fetch restarts at RESET_PC.

Verification
REQ-033 Sequential run: mem returns 16'h8105 @0, 16'hC060 @1, ack in 1 cycle, cmd_ready=1 -> COMMAND sequence 8105 (pc_out 0), C060 (pc_out 1), mem_addr 0,1,2; cmd_valid pattern 1,0,1,0.
REQ-034 Back-pressure and slow memory: ack after 3 wait cycles, cmd_ready low 4 cycles -> mem_addr/mem_req stable 4 cycles; COMMAND stable and cmd_valid=1 through stall; single accept only.
REQ-035 Branch: accept at pc_out=16'h0010 with PC_load=1, pc_target=16'h0040 -> next mem_addr=16'h0040; PC_load=1 during non-accept cycle -> no effect, next mem_addr=16'h0011.
REQ-036 Wrap: RESET_PC=16'hFFFF, accept non-branch -> next mem_addr=16'h0000.
REQ-037 HLT: accept of 16'hC0F0 with PC_load=1 -> halted=1, mem_req=0, cmd_valid=0 indefinitely; stray mem_ack ignored.
REQ-038 Async reset mid-FETCH (mem_req=1, mem_addr=16'h0023): rst pulse between clk edges -> mem_req=0 before next edge; after release, one IDLE cycle, then mem_addr=RESET_PC, mem_req=1.
